// File: rtl/phase_sequencer.sv
// Multi-phase clock-enable generator: one strobe per phase, NPHASE phases per instruction,
// with free-run, single-step, pause-at-boundary and latched halt control.
module phase_sequencer #(
  parameter int NPHASE    = 5,
  parameter int PHASE_LEN = 2,
  parameter int CNT_W     = 16
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      runreq,
  input  logic                      stepreq,
  input  logic                      pausereq,
  input  logic                      haltin,
  output logic [NPHASE-1:0]         phase,
  output logic [$clog2(NPHASE)-1:0] phaseidx,
  output logic                      running,
  output logic                      halted,
  output logic [CNT_W-1:0]          instrcount
);

  localparam int PW = $clog2(NPHASE);
  localparam int SW = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(NPHASE - 1);
  localparam logic [SW-1:0] SC_LAST = SW'(PHASE_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, STEP, HALTED} state_t;

  state_t           st, st_n;
  logic [PW-1:0]    ph, ph_n;
  logic [SW-1:0]    sc, sc_n;
  logic             haltreq, haltreq_n;
  logic             stopreq, stopreq_n;
  logic [CNT_W-1:0] cnt_n;
  logic             last;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      st         <= IDLE;
      ph         <= '0;
      sc         <= '0;
      haltreq    <= 1'b0;
      stopreq    <= 1'b0;
      instrcount <= '0;
    end else begin
      st         <= st_n;
      ph         <= ph_n;
      sc         <= sc_n;
      haltreq    <= haltreq_n;
      stopreq    <= stopreq_n;
      instrcount <= cnt_n;
    end
  end

  assign running  = (st == RUN) || (st == STEP);
  assign halted   = (st == HALTED);
  assign phaseidx = ph;
  assign last     = (ph == PH_LAST) && (sc == SC_LAST);

  always_comb begin
    phase = '0;
    for (int i = 0; i < NPHASE; i++) begin
      phase[i] = running && (sc == '0) && (ph == PW'(i));
    end
  end

  always_comb begin
    st_n      = st;
    ph_n      = ph;
    sc_n      = sc;
    haltreq_n = haltreq;
    stopreq_n = stopreq;
    cnt_n     = instrcount;

    // Phase/sub-clock counters advance on every active clock, wrapping at the instruction end.
    if (running) begin
      if (sc == SC_LAST) begin
        sc_n = '0;
        ph_n = last ? '0 : ph + PW'(1);
      end else begin
        sc_n = sc + SW'(1);
      end
      if (last) cnt_n = instrcount + CNT_W'(1);
    end

    case (st)
      IDLE: begin
        ph_n = '0;
        sc_n = '0;
        if (haltin)       st_n = HALTED;
        else if (runreq)  st_n = RUN;
        else if (stepreq) st_n = STEP;
      end
      RUN: begin
        if (haltin)        haltreq_n = 1'b1;
        if (pausereq)      stopreq_n = 1'b1;
        else if (runreq)   stopreq_n = 1'b0;
        if (last) begin
          if (haltreq) begin
            st_n = HALTED;
          end else if (stopreq) begin
            st_n      = IDLE;
            stopreq_n = 1'b0;
          end
        end
      end
      STEP: begin
        if (haltin) haltreq_n = 1'b1;
        if (last)   st_n = haltreq ? HALTED : IDLE;
      end
      default: begin
        st_n = HALTED;
      end
    endcase
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: vector table for run/pause timing, hand sequences
// for step, halt, reset-abort, counter wrap (CNT_W=4) and PHASE_LEN=1.
module tb_phase_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // main instance: NPHASE=5, PHASE_LEN=2, CNT_W=16
  logic m_resetn, m_run, m_step, m_pause, m_halt;
  logic [4:0] m_phase;
  logic [2:0] m_idx;
  logic m_running, m_halted;
  logic [15:0] m_cnt;

  phase_sequencer #(.NPHASE(5), .PHASE_LEN(2), .CNT_W(16)) u_main (
    .clock(clock), .resetn(m_resetn), .runreq(m_run), .stepreq(m_step),
    .pausereq(m_pause), .haltin(m_halt), .phase(m_phase), .phaseidx(m_idx),
    .running(m_running), .halted(m_halted), .instrcount(m_cnt));

  // counter-wrap instance: CNT_W=4
  logic w_resetn, w_run;
  logic [4:0] w_phase;
  logic [2:0] w_idx;
  logic w_running, w_halted;
  logic [3:0] w_cnt;

  phase_sequencer #(.NPHASE(5), .PHASE_LEN(2), .CNT_W(4)) u_wrap (
    .clock(clock), .resetn(w_resetn), .runreq(w_run), .stepreq(1'b0),
    .pausereq(1'b0), .haltin(1'b0), .phase(w_phase), .phaseidx(w_idx),
    .running(w_running), .halted(w_halted), .instrcount(w_cnt));

  // single-clock phase instance: PHASE_LEN=1
  logic p_resetn, p_run;
  logic [4:0] p_phase;
  logic [2:0] p_idx;
  logic p_running, p_halted;
  logic [15:0] p_cnt;

  phase_sequencer #(.NPHASE(5), .PHASE_LEN(1), .CNT_W(16)) u_p1 (
    .clock(clock), .resetn(p_resetn), .runreq(p_run), .stepreq(1'b0),
    .pausereq(1'b0), .haltin(1'b0), .phase(p_phase), .phaseidx(p_idx),
    .running(p_running), .halted(p_halted), .instrcount(p_cnt));

  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // inputs packed as {resetn, runreq, stepreq, pausereq, haltin}
  localparam logic [4:0] I_RST   = 5'b00000;
  localparam logic [4:0] I_NOP   = 5'b10000;
  localparam logic [4:0] I_RUN   = 5'b11000;
  localparam logic [4:0] I_STEP  = 5'b10100;
  localparam logic [4:0] I_PAUSE = 5'b10010;

  typedef struct {
    logic [4:0]  in;
    logic [4:0]  ph;
    logic [2:0]  idx;
    logic [1:0]  rh;   // {running, halted}
    logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] in, input logic [4:0] ph, input logic [2:0] idx,
                              input logic [1:0] rh, input logic [15:0] cnt);
    vec_t v;
    v.in = in; v.ph = ph; v.idx = idx; v.rh = rh; v.cnt = cnt;
    return v;
  endfunction

  task automatic m_reset();
    m_resetn = 1'b0;
    tick();
    m_resetn = 1'b1;
  endtask

  vec_t tbl[26];
  int   sum;

  initial begin
    m_resetn = 1'b0; m_run = 1'b0; m_step = 1'b0; m_pause = 1'b0; m_halt = 1'b0;
    w_resetn = 1'b0; w_run = 1'b0;
    p_resetn = 1'b0; p_run = 1'b0;

    // Each row: inputs held for one cycle, expected outputs after the following edge.
    tbl[0]  = mk(I_RST,   5'b00000, 3'd0, 2'b00, 16'd0);
    tbl[1]  = mk(I_NOP,   5'b00000, 3'd0, 2'b00, 16'd0);
    tbl[2]  = mk(I_RUN,   5'b00001, 3'd0, 2'b10, 16'd0);
    tbl[3]  = mk(I_NOP,   5'b00000, 3'd0, 2'b10, 16'd0);
    tbl[4]  = mk(I_NOP,   5'b00010, 3'd1, 2'b10, 16'd0);
    tbl[5]  = mk(I_NOP,   5'b00000, 3'd1, 2'b10, 16'd0);
    tbl[6]  = mk(I_NOP,   5'b00100, 3'd2, 2'b10, 16'd0);
    tbl[7]  = mk(I_NOP,   5'b00000, 3'd2, 2'b10, 16'd0);
    tbl[8]  = mk(I_NOP,   5'b01000, 3'd3, 2'b10, 16'd0);
    tbl[9]  = mk(I_NOP,   5'b00000, 3'd3, 2'b10, 16'd0);
    tbl[10] = mk(I_NOP,   5'b10000, 3'd4, 2'b10, 16'd0);
    tbl[11] = mk(I_NOP,   5'b00000, 3'd4, 2'b10, 16'd0);
    tbl[12] = mk(I_NOP,   5'b00001, 3'd0, 2'b10, 16'd1);
    tbl[13] = mk(I_RST,   5'b00000, 3'd0, 2'b00, 16'd0);
    tbl[14] = mk(I_RUN,   5'b00001, 3'd0, 2'b10, 16'd0);
    tbl[15] = mk(I_NOP,   5'b00000, 3'd0, 2'b10, 16'd0);
    tbl[16] = mk(I_STEP,  5'b00010, 3'd1, 2'b10, 16'd0);
    tbl[17] = mk(I_NOP,   5'b00000, 3'd1, 2'b10, 16'd0);
    tbl[18] = mk(I_PAUSE, 5'b00100, 3'd2, 2'b10, 16'd0);
    tbl[19] = mk(I_NOP,   5'b00000, 3'd2, 2'b10, 16'd0);
    tbl[20] = mk(I_NOP,   5'b01000, 3'd3, 2'b10, 16'd0);
    tbl[21] = mk(I_NOP,   5'b00000, 3'd3, 2'b10, 16'd0);
    tbl[22] = mk(I_NOP,   5'b10000, 3'd4, 2'b10, 16'd0);
    tbl[23] = mk(I_NOP,   5'b00000, 3'd4, 2'b10, 16'd0);
    tbl[24] = mk(I_NOP,   5'b00000, 3'd0, 2'b00, 16'd1);
    tbl[25] = mk(I_NOP,   5'b00000, 3'd0, 2'b00, 16'd1);

    tick(); tick();
    w_resetn = 1'b1; p_resetn = 1'b1;

    for (int i = 0; i < 26; i++) begin
      {m_resetn, m_run, m_step, m_pause, m_halt} = tbl[i].in;
      tick();
      chk($sformatf("vec%0d.phase", i),    32'(m_phase),               32'(tbl[i].ph));
      chk($sformatf("vec%0d.phaseidx", i), 32'(m_idx),                 32'(tbl[i].idx));
      chk($sformatf("vec%0d.run_halt", i), 32'({m_running, m_halted}), 32'(tbl[i].rh));
      chk($sformatf("vec%0d.count", i),    32'(m_cnt),                 32'(tbl[i].cnt));
    end
    {m_resetn, m_run, m_step, m_pause, m_halt} = I_NOP;

    // three single steps
    m_reset();
    for (int k = 1; k <= 3; k++) begin
      m_step = 1'b1;
      tick();
      m_step = 1'b0;
      sum = $countones(m_phase);
      for (int c = 0; c < 11; c++) begin
        tick();
        sum += $countones(m_phase);
      end
      chk($sformatf("step%0d.strobes", k), 32'(sum),       32'd5);
      chk($sformatf("step%0d.running", k), 32'(m_running), 32'd0);
      chk($sformatf("step%0d.count", k),   32'(m_cnt),     32'(k));
    end

    // halt pulse during phase 2 of a free-running instruction
    m_reset();
    m_run = 1'b1; tick(); m_run = 1'b0;
    tick(); tick(); tick(); tick();
    chk("halt.pre_phase", 32'(m_phase), 32'b00100);
    m_halt = 1'b1; tick(); m_halt = 1'b0;
    chk("halt.not_yet", 32'(m_halted), 32'd0);
    tick();
    chk("halt.phase3", 32'(m_phase), 32'b01000);
    tick(); tick();
    chk("halt.phase4", 32'(m_phase), 32'b10000);
    chk("halt.still_running", 32'(m_running), 32'd1);
    tick(); tick();
    chk("halt.halted", 32'(m_halted), 32'd1);
    chk("halt.running", 32'(m_running), 32'd0);
    chk("halt.phase_zero", 32'(m_phase), 32'd0);
    chk("halt.count", 32'(m_cnt), 32'd1);
    m_run = 1'b1; tick(); m_run = 1'b0;
    m_step = 1'b1; tick(); m_step = 1'b0;
    sum = $countones(m_phase);
    for (int c = 0; c < 12; c++) begin
      tick();
      sum += $countones(m_phase);
    end
    chk("halt.ignored_strobes", 32'(sum), 32'd0);
    chk("halt.sticky", 32'(m_halted), 32'd1);
    chk("halt.count_after", 32'(m_cnt), 32'd1);

    // halt input while idle
    m_reset();
    m_halt = 1'b1; tick(); m_halt = 1'b0;
    chk("idlehalt.halted", 32'(m_halted), 32'd1);
    chk("idlehalt.running", 32'(m_running), 32'd0);

    // reset during phase 3 aborts the instruction
    m_reset();
    m_run = 1'b1; tick(); m_run = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    chk("abort.phaseidx_pre", 32'(m_idx), 32'd3);
    m_resetn = 1'b0; tick();
    chk("abort.phase", 32'(m_phase), 32'd0);
    chk("abort.phaseidx", 32'(m_idx), 32'd0);
    chk("abort.running", 32'(m_running), 32'd0);
    chk("abort.count", 32'(m_cnt), 32'd0);
    m_resetn = 1'b1; tick();
    chk("abort.no_strobe", 32'(m_phase), 32'd0);

    // counter wrap with CNT_W=4
    w_run = 1'b1; tick(); w_run = 1'b0;
    for (int c = 0; c < 150; c++) tick();
    chk("wrap.count15", 32'(w_cnt), 32'd15);
    for (int c = 0; c < 10; c++) tick();
    chk("wrap.count0", 32'(w_cnt), 32'd0);
    for (int c = 0; c < 10; c++) tick();
    chk("wrap.count1", 32'(w_cnt), 32'd1);
    chk("wrap.running", 32'(w_running), 32'd1);

    // PHASE_LEN=1: strobes on consecutive clocks, phase 0 right after phase 4
    p_run = 1'b1; tick(); p_run = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("p1.phase%0d", k), 32'(p_phase), 32'(5'b00001 << (k % 5)));
      chk($sformatf("p1.idx%0d", k),   32'(p_idx),   32'(k % 5));
      if (k < 5) tick();
    end
    chk("p1.count", 32'(p_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
